// File: rtl/note_sequencer.sv
// Melody autoplay controller driving the square-wave tone generator, with manual switch override.
// Optional feature: define NOTE_SEQ_LOOP_EN to add the loop_en input (restart the song instead of ending).
module note_sequencer #(
  parameter int CLK_HZ     = 12000000,
  parameter int BEAT_HZ    = 8,
  parameter int GAP_CYCLES = 120000,
  parameter int SONG_LEN   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
`ifdef NOTE_SEQ_LOOP_EN
  input  logic        loop_en,
`endif
  input  logic [5:0]  manual_sw,
  output logic [21:0] tone_div,
  output logic        tone_en,
  output logic [5:0]  led,
  output logic        busy,
  output logic        done
);

  localparam int TICK = CLK_HZ / BEAT_HZ;
  localparam int AW   = (SONG_LEN > 1)   ? $clog2(SONG_LEN)   : 1;
  localparam int PW   = (TICK > 1)       ? $clog2(TICK)       : 1;
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

  state_t          state;
  logic [AW-1:0]   addr;
  logic [PW-1:0]   prescaler;
  logic [3:0]      beat_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [3:0]      cur_note;

  logic [7:0]      rom_q;
  logic [3:0]      rom_note;
  logic [3:0]      rom_dur;
  logic [5:0]      sw_req;
  logic            manual_valid;
  logic [3:0]      manual_note;
  logic            loop_taken;

  function automatic logic [21:0] note_div(input logic [3:0] n);
    case (n)
      4'd0:    note_div = 22'(CLK_HZ / 440 / 2);
      4'd1:    note_div = 22'(CLK_HZ / 466 / 2);
      4'd2:    note_div = 22'(CLK_HZ / 493 / 2);
      4'd3:    note_div = 22'(CLK_HZ / 523 / 2);
      4'd4:    note_div = 22'(CLK_HZ / 554 / 2);
      4'd5:    note_div = 22'(CLK_HZ / 587 / 2);
      default: note_div = 22'd0;
    endcase
  endfunction

  // Melody: {note, dur}; a zero duration marks the end of the song.
  function automatic logic [7:0] rom_word(input logic [AW-1:0] a);
    int idx;
    idx = int'(a);
    case (idx)
      0:       rom_word = 8'h02;
      1:       rom_word = 8'h32;
      2:       rom_word = 8'h54;
      3:       rom_word = 8'hF1;
      4:       rom_word = 8'h22;
      default: rom_word = 8'h00;
    endcase
  endfunction

  assign rom_q    = rom_word(addr);
  assign rom_note = rom_q[7:4];
  assign rom_dur  = rom_q[3:0];

  // Switches are active-low; a request needs exactly one pressed switch.
  assign sw_req       = ~manual_sw;
  assign manual_valid = (sw_req != 6'd0) && ((sw_req & (sw_req - 6'd1)) == 6'd0);

  always_comb begin
    manual_note = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (sw_req[i]) manual_note = 4'(i);
    end
  end

`ifdef NOTE_SEQ_LOOP_EN
  assign loop_taken = loop_en;
`else
  assign loop_taken = 1'b0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      prescaler <= '0;
      beat_cnt  <= 4'd0;
      gap_cnt   <= '0;
      cur_note  <= 4'd15;
      tone_div  <= 22'd0;
      tone_en   <= 1'b0;
      led       <= 6'd0;
    end else begin
      if (manual_valid) begin
        tone_en  <= 1'b1;
        tone_div <= note_div(manual_note);
        led      <= sw_req;
      end else if (state == PLAY && cur_note < 4'd6) begin
        tone_en  <= 1'b1;
        tone_div <= note_div(cur_note);
        led      <= 6'd1 << cur_note;
      end else begin
        tone_en  <= 1'b0;
        tone_div <= 22'd0;
        led      <= 6'd0;
      end

      // A manual press freezes the melody in place; only stop gets through.
      if (stop) begin
        state <= IDLE;
        addr  <= '0;
      end else if (!manual_valid) begin
        case (state)
          IDLE: begin
            if (start) begin
              state <= LOAD;
              addr  <= '0;
            end
          end
          LOAD: begin
            if (rom_dur == 4'd0) begin
              if (loop_taken) addr <= '0;
              else            state <= DONE;
            end else begin
              state     <= PLAY;
              beat_cnt  <= rom_dur;
              prescaler <= PW'(TICK - 1);
              cur_note  <= rom_note;
            end
          end
          PLAY: begin
            if (prescaler == '0) begin
              prescaler <= PW'(TICK - 1);
              beat_cnt  <= beat_cnt - 4'd1;
              if (beat_cnt == 4'd1) begin
                state   <= GAP;
                gap_cnt <= GW'(GAP_CYCLES - 1);
              end
            end else begin
              prescaler <= prescaler - PW'(1);
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              if (addr == AW'(SONG_LEN - 1)) begin
                if (loop_taken) begin
                  state <= LOAD;
                  addr  <= '0;
                end else begin
                  state <= DONE;
                end
              end else begin
                state <= LOAD;
                addr  <= addr + AW'(1);
              end
            end else begin
              gap_cnt <= gap_cnt - GW'(1);
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer with TICK=10 and a 3-cycle gap.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [5:0]  manual_sw;
  logic [21:0] tone_div;
  logic        tone_en;
  logic [5:0]  led;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  note_sequencer #(
    .CLK_HZ    (12000000),
    .BEAT_HZ   (1200000),
    .GAP_CYCLES(3),
    .SONG_LEN  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
`ifdef NOTE_SEQ_LOOP_EN
    .loop_en  (1'b0),
`endif
    .manual_sw(manual_sw),
    .tone_div (tone_div),
    .tone_en  (tone_en),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output trace of an undisturbed song, counted in cycles after the start pulse cycle.
  function automatic logic [21:0] song_div(input int c);
    if (c >= 3   && c <= 22)  return 22'd13636;
    if (c >= 27  && c <= 46)  return 22'd11472;
    if (c >= 51  && c <= 90)  return 22'd10221;
    if (c >= 109 && c <= 128) return 22'd12170;
    return 22'd0;
  endfunction

  function automatic logic [5:0] led_of(input logic [21:0] d);
    case (d)
      22'd13636: return 6'b000001;
      22'd12875: return 6'b000010;
      22'd12170: return 6'b000100;
      22'd11472: return 6'b001000;
      22'd10830: return 6'b010000;
      22'd10221: return 6'b100000;
      default:   return 6'b000000;
    endcase
  endfunction

  task automatic test_reset();
    logic [30:0] got;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 10; c++) step();
    n_checks++;
    if ({tone_en, tone_div} !== {1'b1, 22'd13636}) begin
      n_fail++;
      $display("[TB] FAIL reset_pre_play got en=%0b div=%0d exp en=1 div=13636", tone_en, tone_div);
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {tone_en, tone_div, led, busy, done};
    n_checks++;
    if (got !== 31'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_async got=%h exp=0", got);
    end
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++;
      if ({busy, tone_en, done} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL reset_release c=%0d got busy=%0b en=%0b done=%0b exp 0 0 0", c, busy, tone_en, done);
      end
    end
  endtask

  task automatic test_full_song();
    logic [30:0] got, exp;
    logic [21:0] d;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 140; c++) begin
      d   = song_div(c);
      exp = {(d != 22'd0), d, led_of(d), (c <= 132), (c == 132)};
      got = {tone_en, tone_div, led, busy, done};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL song c=%0d got en=%0b div=%0d led=%b busy=%0b done=%0b exp en=%0b div=%0d led=%b busy=%0b done=%0b",
                 c, got[30], got[29:8], got[7:2], got[1], got[0], exp[30], exp[29:8], exp[7:2], exp[1], exp[0]);
      end
      // start while busy must be ignored
      start = (c == 60);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_manual_override();
    logic [28:0] got, exp;
    logic [21:0] d;
    int d_on;
    d_on = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 115; c++) begin
      if (c >= 61 && c <= 75)       d = 22'd12170;
      else if (c >= 51 && c <= 60)  d = 22'd10221;
      else if (c >= 76 && c <= 105) d = 22'd10221;
      else if (c >= 106)            d = 22'd0;
      else                          d = song_div(c);
      exp = {(d != 22'd0), d, led_of(d)};
      got = {tone_en, tone_div, led};
      if (tone_en && tone_div == 22'd10221) d_on++;
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("[TB] FAIL manual c=%0d got en=%0b div=%0d led=%b exp en=%0b div=%0d led=%b",
                 c, got[28], got[27:6], got[5:0], exp[28], exp[27:6], exp[5:0]);
      end
      manual_sw = (c >= 60 && c <= 74) ? 6'b111011 : 6'b111111;
      step();
    end
    n_checks++;
    if (d_on != 40) begin
      n_fail++;
      $display("[TB] FAIL manual_d_ontime got=%0d exp=40", d_on);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL manual_stop busy got=%0b exp=0", busy);
    end
    step();
  endtask

  task automatic test_invalid_and_conflict();
    manual_sw = 6'b111100;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if ({tone_en, tone_div, led} !== 29'd0) begin
        n_fail++;
        $display("[TB] FAIL invalid_sw c=%0d got en=%0b div=%0d led=%b exp 0", c, tone_en, tone_div, led);
      end
    end
    manual_sw = 6'b111110;
    step();
    n_checks++;
    if ({tone_en, tone_div, led, busy} !== {1'b1, 22'd13636, 6'b000001, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL idle_manual got en=%0b div=%0d led=%b busy=%0b exp en=1 div=13636 led=000001 busy=0",
               tone_en, tone_div, led, busy);
    end
    manual_sw = 6'b111111;
    step();
    n_checks++;
    if (tone_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL idle_release got en=%0b exp=0", tone_en);
    end
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({busy, tone_en} !== 2'b00) begin
        n_fail++;
        $display("[TB] FAIL start_stop c=%0d got busy=%0b en=%0b exp 0 0", c, busy, tone_en);
      end
      step();
    end
  endtask

  task automatic test_stop_mid_gap();
    logic [21:0] d;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 23; c++) step();
    n_checks++;
    if ({busy, tone_en} !== 2'b10) begin
      n_fail++;
      $display("[TB] FAIL gap_state got busy=%0b en=%0b exp 1 0", busy, tone_en);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({busy, done, tone_en} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL stop_gap c=%0d got busy=%0b done=%0b en=%0b exp 0 0 0", c, busy, done, tone_en);
      end
      step();
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      d = song_div(c);
      n_checks++;
      if ({tone_en, tone_div, led, busy} !== {(d != 22'd0), d, led_of(d), 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL replay c=%0d got en=%0b div=%0d led=%b busy=%0b exp div=%0d",
                 c, tone_en, tone_div, led, busy, d);
      end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    manual_sw = 6'b111111;
    step();
    step();
    rst_n = 1'b1;
    step();
    $display("[TB] starting directed tests");
    test_reset();
    test_full_song();
    test_manual_override();
    test_invalid_and_conflict();
    test_stop_mid_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Autoplay controller for the square-wave tone generator. It steps through a fixed melody ROM and times each note in beats from a clock prescaler. Each cycle it drives the generator's half-period divider and enable, and arbitrates with the manual note switches; a manual press always wins and pauses the melody. It sits between the board switches/start buttons and the tone generator's divider/enable inputs.

Parameters:
CLK_HZ, 12000000, system clock frequency; divider values are CLK_HZ/f/2 with integer division, left to right.
BEAT_HZ, 8, beat tick rate; TICK = CLK_HZ/BEAT_HZ cycles per beat.
GAP_CYCLES, 120000, silent cycles inserted after every note (articulation).
SONG_LEN, 16, ROM depth; address width is clog2(SONG_LEN).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins playback from address 0
stop  in  1  one-cycle pulse; aborts playback
manual_sw  in  6  active-low note switches; valid only if exactly one bit is 0
tone_div  out  22  half-period divider to the tone generator
tone_en  out  1  tone generator enable
led  out  6  one-hot indicator of the sounding note
busy  out  1  sequencer not in IDLE
done  out  1  one-cycle pulse at normal end of song

Behaviour:
- Reset (async, rst_n=0): state IDLE, addr 0, prescaler 0, beat_cnt 0. Outputs tone_div=0, tone_en=0, led=0, busy=0, done=0.
- ROM entry is 8 bits {note[3:0], dur[3:0]}.
  - Note codes and dividers: 0=A440, 1=A#466, 2=B493, 3=C523, 4=C#554, 5=D587, 15=rest. Codes 6-14 are treated as rest.
  - dur=0 is the end marker.
  - Contents: {0,2},{3,2},{5,4},{15,1},{2,2},{0,0}; all remaining entries {0,0}.
- States:
  - IDLE: start=1 -> LOAD with addr=0.
  - LOAD (1 cycle): read ROM[addr]. dur=0 -> DONE. Otherwise -> PLAY, beat_cnt=dur, prescaler=TICK-1.
  - PLAY: prescaler counts down; tick fires when it hits 0, then it reloads TICK-1. Each tick decrements beat_cnt. Tick with beat_cnt=1 -> GAP. PLAY therefore lasts exactly dur*TICK cycles.
  - GAP: GAP_CYCLES cycles, then LOAD with addr+1. If addr=SONG_LEN-1, go to DONE instead (no wrap).
  - DONE (1 cycle): done=1 -> IDLE.
- stop=1 in any state: next state IDLE, addr=0, done stays 0. stop has priority over start in the same cycle. start while busy is ignored.
- Arbitration:
  - A valid manual pattern overrides: tone_div=divider of that switch (bit0=A ... bit5=D), tone_en=1, led=one-hot of the switch.
  - While overridden, prescaler, beat_cnt and state are frozen, except that stop is still honoured.
  - Invalid or all-ones manual_sw means no manual request.
- Without override:
  - In PLAY with a tone note: tone_en=1, tone_div=note divider, led=one-hot of note.
  - In every other state, and for rests: tone_en=0, tone_div=0, led=0.
- tone_div, tone_en and led are registered; they lag state/manual changes by exactly 1 cycle.
- busy is combinational from state (state != IDLE).

Optional Feature:
NOTE_SEQ_LOOP_EN: when defined, an extra 1-bit input port loop_en is added.
- Loop taken (loop_en=1): at an end marker, or after GAP at addr=SONG_LEN-1, the sequencer goes to LOAD with addr=0. No DONE and no done pulse occur.
- Loop not taken (loop_en=0): behaviour is identical to the macro undefined.
- Macro undefined: the port is absent and the song always ends in DONE.

Test Plan:
All scenarios use CLK_HZ=12000000, BEAT_HZ=1200000 (TICK=10) and GAP_CYCLES=3.
- Reset mid-PLAY: assert rst_n=0 -> all outputs 0 immediately (asynchronous). After release, busy=0 until the next start.
- Start pulse at cycle 0 -> LOAD at cycle 1, PLAY at cycle 2.
  - tone_en=1 with tone_div=13636 and led=000001 for exactly 20 cycles starting at cycle 3.
  - Then 4 silent cycles (GAP 3 + LOAD 1), then tone_div=11472 for 20 cycles.
- Full song: tone sequence 13636, 11472, 10221 (40 cycles), 10 silent beat cycles, 12170.
  - Then a single done pulse, busy=0 afterwards, with no tone after the end marker.
- Manual override during note 3: hold manual_sw=111011 for 15 cycles mid-note.
  - During override: tone_div=12170, led=000100.
  - On release: D resumes with its remaining beat time intact; total D on-time equals 40 cycles.
- Invalid manual_sw=111100 while idle -> tone_en stays 0. start and stop in the same cycle -> busy stays 0.
- stop pulse mid-GAP -> IDLE next cycle, no done pulse. A later start replays from note A.
